// File: rtl/cache_mem_arbiter_if.sv
// Bundles the icache, dcache and burst-memory signals that meet at the arbiter.
// The slave modport is the arbiter's view; the master modport is the caches/memory side.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BEAT_WIDTH-1:0] mem_wdata;
    logic [BEAT_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between icache and dcache,
// splitting each cache line into BEATS memory beats and returning a one-cycle response.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_mem_arbiter_if.slave   bus
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam int OFF   = $clog2(LINE_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;
    typedef enum logic {GRANT_I, GRANT_D} grant_e;

    state_e                state_q, state_d;
    grant_e                last_q, last_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  load_line;
    logic                  capture;
    logic                  d_req;
    logic [BEAT_WIDTH-1:0] beat_w [BEATS];
    logic [LINE_WIDTH-1:0] line_w;

    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GRANT_I;
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    // Line buffer held as one register per beat; loaded whole for writebacks, beat-wise for fills.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        logic [BEAT_WIDTH-1:0] beat_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                beat_q <= '0;
            end else if (load_line) begin
                beat_q <= bus.d_wdata[gi*BEAT_WIDTH +: BEAT_WIDTH];
            end else if (capture && (count_q == CW'(gi))) begin
                beat_q <= bus.mem_rdata;
            end
        end

        assign beat_w[gi]                            = beat_q;
        assign line_w[gi*BEAT_WIDTH +: BEAT_WIDTH]   = beat_q;
    end

    assign bus.i_rdata = line_w;
    assign bus.d_rdata = line_w;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        count_d       = count_q;
        addr_d        = addr_q;
        load_line     = 1'b0;
        capture       = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_resp    = 1'b0;
        bus.d_resp    = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (d_req && (!bus.i_read || last_q == GRANT_I)) begin
                    state_d   = bus.d_write ? D_WR : D_RD;
                    last_d    = GRANT_D;
                    count_d   = '0;
                    addr_d    = {bus.d_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    load_line = bus.d_write;
                end else if (bus.i_read) begin
                    state_d   = I_RD;
                    last_d    = GRANT_I;
                    count_d   = '0;
                    addr_d    = {bus.i_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                end
            end
            I_RD, D_RD: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = addr_q;
                if (bus.mem_resp) begin
                    capture = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            D_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = beat_w[count_q];
                if (bus.mem_resp) begin
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bus.i_resp = (last_q == GRANT_I);
                bus.d_resp = (last_q == GRANT_D);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a behavioural burst memory answers at the
// falling edge while scenario tasks drive the caches and compare against hand-built values.
module tb_cache_mem_arbiter;
    logic clk;
    logic rst;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] rd_beats [4];
    logic [31:0] addr_log [$];
    logic [63:0] wdata_log [$];
    int          resp_limit = 4;
    bit          gap_mode   = 1'b0;
    int          beats_done = 0;

    // Memory model: one beat per falling edge while a burst is open (every other edge in gap mode).
    initial begin
        int  beat_idx;
        bit  gap_tog;
        beat_idx      = 0;
        gap_tog       = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = '0;
            if (rst || !(bus.mem_read || bus.mem_write)) begin
                beat_idx = 0;
                gap_tog  = 1'b0;
            end else if (beat_idx < resp_limit) begin
                if (gap_mode && !gap_tog) begin
                    gap_tog = 1'b1;
                end else begin
                    gap_tog = 1'b0;
                    if (beat_idx == 0) addr_log.push_back(bus.mem_addr);
                    if (bus.mem_write) wdata_log.push_back(bus.mem_wdata);
                    bus.mem_rdata = rd_beats[beat_idx];
                    bus.mem_resp  = 1'b1;
                    beat_idx++;
                    beats_done++;
                end
            end
        end
    end

    task automatic wait_resp(output int cyc, output int act, output bit timed_out,
                             output bit saw_i, output bit saw_d, output bit both_hi,
                             output bit dropped);
        bit seen_act;
        cyc = 0; act = 0; timed_out = 1'b1; saw_i = 1'b0; saw_d = 1'b0;
        both_hi = 1'b0; dropped = 1'b0; seen_act = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_read && bus.mem_write) both_hi = 1'b1;
            if (bus.i_resp || bus.d_resp) begin
                saw_i = bus.i_resp;
                saw_d = bus.d_resp;
                timed_out = 1'b0;
                break;
            end
            if (bus.mem_read || bus.mem_write) begin
                act++;
                seen_act = 1'b1;
            end else if (seen_act) begin
                dropped = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (bus.mem_read !== 1'b0) $display("FAIL reset_mem_read: got %0b expected 0", bus.mem_read); else pass_cnt++;
        total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL reset_mem_write: got %0b expected 0", bus.mem_write); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.i_resp !== 1'b0) $display("FAIL reset_i_resp: got %0b expected 0", bus.i_resp); else pass_cnt++;
        total_cnt++; if (bus.d_resp !== 1'b0) $display("FAIL reset_d_resp: got %0b expected 0", bus.d_resp); else pass_cnt++;
        total_cnt++; if (bus.i_rdata !== 256'h0) $display("FAIL reset_i_rdata: got %h expected 0", bus.i_rdata); else pass_cnt++;
        total_cnt++; if (bus.d_rdata !== 256'h0) $display("FAIL reset_d_rdata: got %h expected 0", bus.d_rdata); else pass_cnt++;
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_icache_read();
        int cyc, act; bit to, si, sd, bh, dr;
        rd_beats[0] = 64'hAAAA_0000_0000_000A; rd_beats[1] = 64'hBBBB_0000_0000_000B;
        rd_beats[2] = 64'hCCCC_0000_0000_000C; rd_beats[3] = 64'hDDDD_0000_0000_000D;
        addr_log.delete();
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0064;
        wait_resp(cyc, act, to, si, sd, bh, dr);
        total_cnt++; if (to) $display("FAIL icache_timeout: got timeout expected i_resp"); else pass_cnt++;
        total_cnt++; if (si !== 1'b1 || sd !== 1'b0) $display("FAIL icache_resp_side: got i=%0b d=%0b expected i=1 d=0", si, sd); else pass_cnt++;
        total_cnt++; if (bus.i_rdata !== {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A})
            $display("FAIL icache_rdata: got %h expected DCBA line", bus.i_rdata); else pass_cnt++;
        total_cnt++; if (cyc != 5) $display("FAIL icache_latency: got %0d expected 5", cyc); else pass_cnt++;
        total_cnt++; if (act != 4) $display("FAIL icache_mem_read_cycles: got %0d expected 4", act); else pass_cnt++;
        total_cnt++; if (addr_log.size() != 1 || addr_log[0] !== 32'h0000_0060)
            $display("FAIL icache_mem_addr: got %h (n=%0d) expected 00000060", addr_log[0], addr_log.size()); else pass_cnt++;
        bus.i_read = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (bus.i_resp !== 1'b0) $display("FAIL icache_resp_one_cycle: got %0b expected 0", bus.i_resp); else pass_cnt++;
        total_cnt++; if (bus.mem_read !== 1'b0) $display("FAIL icache_idle_mem_read: got %0b expected 0", bus.mem_read); else pass_cnt++;
        $display("txn icache read addr=00000064 cycles=%0d", cyc);
    endtask

    task automatic test_dcache_write();
        int cyc, act; bit to, si, sd, bh, dr;
        logic [63:0] w [4];
        w[0] = 64'h0123_4567_89AB_CDE0; w[1] = 64'h1111_2222_3333_4441;
        w[2] = 64'h5555_6666_7777_8882; w[3] = 64'h9999_AAAA_BBBB_CCC3;
        addr_log.delete(); wdata_log.delete();
        bus.d_write = 1'b1; bus.d_addr = 32'h1000_0020; bus.d_wdata = {w[3], w[2], w[1], w[0]};
        @(posedge clk); #1;
        total_cnt++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h1000_0020)
            $display("FAIL dwrite_grant: got write=%0b addr=%h expected 1 10000020", bus.mem_write, bus.mem_addr); else pass_cnt++;
        bus.d_wdata = '1; bus.d_addr = 32'hFFFF_FFFF;
        wait_resp(cyc, act, to, si, sd, bh, dr);
        total_cnt++; if (to || sd !== 1'b1 || si !== 1'b0) $display("FAIL dwrite_resp: got to=%0b i=%0b d=%0b expected d_resp only", to, si, sd); else pass_cnt++;
        total_cnt++; if (cyc != 4) $display("FAIL dwrite_latency: got %0d expected 4", cyc); else pass_cnt++;
        total_cnt++; if (bh) $display("FAIL dwrite_both_high: got read&write expected exclusive"); else pass_cnt++;
        total_cnt++; if (wdata_log.size() != 4) $display("FAIL dwrite_beat_count: got %0d expected 4", wdata_log.size()); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (wdata_log[k] !== w[k]) $display("FAIL dwrite_beat%0d: got %h expected %h", k, wdata_log[k], w[k]); else pass_cnt++;
        end
        total_cnt++; if (addr_log[0] !== 32'h1000_0020) $display("FAIL dwrite_mem_addr: got %h expected 10000020", addr_log[0]); else pass_cnt++;
        bus.d_write = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (bus.mem_write !== 1'b0 || bus.d_resp !== 1'b0)
            $display("FAIL dwrite_after: got write=%0b d_resp=%0b expected 0 0", bus.mem_write, bus.d_resp); else pass_cnt++;
        $display("txn dcache write addr=10000020 cycles=%0d", cyc);
    endtask

    task automatic test_tie_after_reset();
        int cyc, act; bit to, si, sd, bh, dr;
        apply_reset();
        rd_beats[0] = 64'h10; rd_beats[1] = 64'h11; rd_beats[2] = 64'h12; rd_beats[3] = 64'h13;
        addr_log.delete();
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0200;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0305;
        wait_resp(cyc, act, to, si, sd, bh, dr);
        total_cnt++; if (to || sd !== 1'b1 || si !== 1'b0) $display("FAIL tie_first_side: got i=%0b d=%0b expected dcache", si, sd); else pass_cnt++;
        total_cnt++; if (bus.d_rdata !== {64'h13, 64'h12, 64'h11, 64'h10}) $display("FAIL tie_d_rdata: got %h expected 13/12/11/10", bus.d_rdata); else pass_cnt++;
        bus.d_read = 1'b0;
        wait_resp(cyc, act, to, si, sd, bh, dr);
        total_cnt++; if (to || si !== 1'b1 || sd !== 1'b0) $display("FAIL tie_second_side: got i=%0b d=%0b expected icache", si, sd); else pass_cnt++;
        bus.i_read = 1'b0;
        total_cnt++; if (addr_log.size() != 2 || addr_log[0] !== 32'h0000_0300 || addr_log[1] !== 32'h0000_0200)
            $display("FAIL tie_addr_order: got %h,%h expected 00000300,00000200", addr_log[0], addr_log[1]); else pass_cnt++;
        @(posedge clk); #1;
        $display("txn tie after reset d then i");
    endtask

    task automatic test_back_to_back();
        int cyc, act; bit to, si, sd, bh, dr;
        bit order [4];
        bit exp_d [4];
        logic [31:0] exp_a [4];
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
        exp_a[0] = 32'h0000_0800; exp_a[1] = 32'h0000_0400; exp_a[2] = 32'h0000_0800; exp_a[3] = 32'h0000_0400;
        addr_log.delete();
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0400;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0800;
        for (int k = 0; k < 4; k++) begin
            wait_resp(cyc, act, to, si, sd, bh, dr);
            total_cnt++; if (to) $display("FAIL b2b_timeout%0d: got timeout expected resp", k); else pass_cnt++;
            order[k] = sd;
            if (sd) bus.d_read = 1'b0; else bus.i_read = 1'b0;
            if (k < 3) begin
                @(posedge clk); #1;
                bus.d_read = 1'b1; bus.i_read = 1'b1;
            end
            $display("txn b2b %0d granted %s", k, sd ? "dcache" : "icache");
        end
        bus.d_read = 1'b0; bus.i_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (order[k] !== exp_d[k]) $display("FAIL b2b_order%0d: got d=%0b expected d=%0b", k, order[k], exp_d[k]); else pass_cnt++;
            total_cnt++; if (addr_log[k] !== exp_a[k]) $display("FAIL b2b_addr%0d: got %h expected %h", k, addr_log[k], exp_a[k]); else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_burst();
        int cyc, act; bit to, si, sd, bh, dr; bit reached, saw_d;
        rd_beats[0] = 64'h20; rd_beats[1] = 64'h21; rd_beats[2] = 64'h22; rd_beats[3] = 64'h23;
        resp_limit = 2; beats_done = 0; reached = 1'b0; saw_d = 1'b0;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0040;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (beats_done >= 2) begin reached = 1'b1; break; end
        end
        total_cnt++; if (!reached) $display("FAIL rst_mid_beats: got %0d beats expected 2", beats_done); else pass_cnt++;
        rst = 1'b1; bus.d_read = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h0)
            $display("FAIL rst_mid_outputs: got read=%0b addr=%h expected 0 0", bus.mem_read, bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.d_rdata !== 256'h0) $display("FAIL rst_mid_discard: got %h expected 0", bus.d_rdata); else pass_cnt++;
        rst = 1'b0; resp_limit = 4;
        repeat (3) begin
            if (bus.d_resp) saw_d = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++; if (saw_d) $display("FAIL rst_mid_no_resp: got d_resp expected none"); else pass_cnt++;
        rd_beats[0] = 64'h30; rd_beats[1] = 64'h31; rd_beats[2] = 64'h32; rd_beats[3] = 64'h33;
        addr_log.delete();
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_1000;
        wait_resp(cyc, act, to, si, sd, bh, dr);
        total_cnt++; if (to || si !== 1'b1 || sd !== 1'b0) $display("FAIL rst_mid_next_resp: got i=%0b d=%0b expected icache", si, sd); else pass_cnt++;
        total_cnt++; if (bus.i_rdata !== {64'h33, 64'h32, 64'h31, 64'h30}) $display("FAIL rst_mid_next_rdata: got %h expected 33/32/31/30", bus.i_rdata); else pass_cnt++;
        total_cnt++; if (addr_log[0] !== 32'h0000_1000) $display("FAIL rst_mid_next_addr: got %h expected 00001000", addr_log[0]); else pass_cnt++;
        bus.i_read = 1'b0;
        @(posedge clk); #1;
        $display("txn reset mid-burst then icache read cycles=%0d", cyc);
    endtask

    task automatic test_gapped_beats();
        int cyc, act; bit to, si, sd, bh, dr;
        rd_beats[0] = 64'hCAFE_0000; rd_beats[1] = 64'hCAFE_0001; rd_beats[2] = 64'hCAFE_0002; rd_beats[3] = 64'hCAFE_0003;
        addr_log.delete();
        gap_mode = 1'b1;
        bus.d_read = 1'b1; bus.d_addr = 32'h2000_0047;
        wait_resp(cyc, act, to, si, sd, bh, dr);
        total_cnt++; if (to || sd !== 1'b1) $display("FAIL gap_resp: got to=%0b d=%0b expected d_resp", to, sd); else pass_cnt++;
        total_cnt++; if (act != 8) $display("FAIL gap_read_cycles: got %0d expected 8", act); else pass_cnt++;
        total_cnt++; if (dr) $display("FAIL gap_read_held: got mem_read drop expected held"); else pass_cnt++;
        total_cnt++; if (bus.d_rdata !== {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000})
            $display("FAIL gap_rdata: got %h expected CAFE0003..CAFE0000", bus.d_rdata); else pass_cnt++;
        total_cnt++; if (addr_log[0] !== 32'h2000_0040) $display("FAIL gap_addr: got %h expected 20000040", addr_log[0]); else pass_cnt++;
        bus.d_read = 1'b0; gap_mode = 1'b0;
        @(posedge clk); #1;
        $display("txn gapped dcache read cycles=%0d", cyc);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int k = 0; k < 4; k++) rd_beats[k] = '0;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_tie_after_reset();
        test_back_to_back();
        test_rst_mid_burst();
        test_gapped_beats();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
